// File: rtl/hvsync_decoder.sv
// Receive-side video timing recovery: locks to external hsync/vsync and regenerates hpos/vpos.
// Define HVSYNC_DECODER_INVERT_EN for active-low sync sources.
module hvsync_decoder #(
    parameter int H_DISPLAY   = 256,
    parameter int V_DISPLAY   = 240,
    parameter int H_TOTAL     = 309,
    parameter int V_TOTAL     = 262,
    parameter int H_EDGE_POS  = 265,
    parameter int V_EDGE_POS  = 254,
    parameter int LOCK_LINES  = 4,
    parameter int UNLOCK_ERRS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       display_on,
    output logic       locked,
    output logic [9:0] line_len,
    output logic       sync_err
);

    localparam logic [9:0] PER_MAX    = 10'd1023;
    localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0] TIMEOUT    = 10'(2 * H_TOTAL);
    localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_LOAD     = 9'(H_EDGE_POS);
    localparam logic [8:0] V_LOAD     = 9'(V_EDGE_POS);
    localparam logic [8:0] LCNT_MAX   = 9'd511;
    localparam logic [7:0] CNT_MAX    = 8'hFF;
    localparam logic [7:0] LOCK_NEED  = 8'(LOCK_LINES);
    localparam logic [7:0] ERR_LIMIT  = 8'(UNLOCK_ERRS);

    typedef enum logic [1:0] {
        HUNT,
        ACQUIRE,
        LOCKED
    } state_t;

    logic       hs;
    logic       vs;
    logic       hs_d;
    logic       vs_d;
    logic       hedge;
    logic       vedge;
    logic [9:0] per_cnt;
    logic [8:0] lcnt;
    logic [9:0] lcnt_sum;
    logic       hgood;
    logic       vgood;
    logic       hwrap;
    logic       timeout;
    logic       bad_h;
    logic       bad_v;

    state_t     state;
    logic [7:0] good;
    logic [7:0] err;
    logic       vseen;
    logic       vok;
    logic [7:0] good_next;
    logic       vok_next;
    logic [7:0] err_inc;

`ifdef HVSYNC_DECODER_INVERT_EN
    localparam logic SYNC_IDLE = 1'b1;
    assign hs = ~hsync_in;
    assign vs = ~vsync_in;
`else
    localparam logic SYNC_IDLE = 1'b0;
    assign hs = hsync_in;
    assign vs = vsync_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_d <= SYNC_IDLE;
            vs_d <= SYNC_IDLE;
        end else begin
            hs_d <= hs;
            vs_d <= vs;
        end
    end

    assign hedge = hs & ~hs_d;
    assign vedge = vs & ~vs_d;

    // per_cnt holds the clocks elapsed since the last hedge, so at the next hedge it is the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cnt  <= '0;
            line_len <= '0;
        end else if (hedge) begin
            per_cnt  <= 10'd1;
            line_len <= per_cnt;
        end else if (per_cnt != PER_MAX) begin
            per_cnt <= per_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcnt <= '0;
        end else if (vedge) begin
            lcnt <= '0;
        end else if (hedge && lcnt != LCNT_MAX) begin
            lcnt <= lcnt + 9'd1;
        end
    end

    assign hgood    = (per_cnt == H_TOTAL_C);
    assign lcnt_sum = {1'b0, lcnt} + {9'd0, hedge};
    assign vgood    = (lcnt_sum == V_TOTAL_C);
    assign timeout  = (per_cnt >= TIMEOUT);
    assign bad_h    = hedge & ~hgood;
    assign bad_v    = vedge & ~vgood;
    assign hwrap    = ~hedge && (hpos >= H_LAST);

    // Beam position free-runs in every state; sync edges only re-phase it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos <= '0;
        end else if (hedge) begin
            hpos <= H_LOAD;
        end else if (hpos >= H_LAST) begin
            hpos <= '0;
        end else begin
            hpos <= hpos + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vpos <= '0;
        end else if (vedge) begin
            vpos <= V_LOAD;
        end else if (hwrap) begin
            vpos <= (vpos >= V_LAST) ? 9'd0 : vpos + 9'd1;
        end
    end

    assign display_on = locked && (hpos < 9'(H_DISPLAY)) && (vpos < 9'(V_DISPLAY));

    always_comb begin
        good_next = good;
        vok_next  = vok;
        if (hedge) begin
            good_next = hgood ? ((good == CNT_MAX) ? good : good + 8'd1) : 8'd0;
        end
        if (vedge) begin
            vok_next = vseen & vgood;
        end
    end

    assign err_inc = (err == CNT_MAX) ? err : err + 8'd1;

    // Lock decisions use this cycle's edge results so locked/sync_err follow the edge by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            good     <= '0;
            err      <= '0;
            vseen    <= 1'b0;
            vok      <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (state)
                HUNT: begin
                    good   <= '0;
                    err    <= '0;
                    vseen  <= 1'b0;
                    vok    <= 1'b0;
                    locked <= 1'b0;
                    if (hedge) begin
                        state <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    good <= good_next;
                    vok  <= vok_next;
                    if (vedge) begin
                        vseen <= 1'b1;
                    end
                    if (timeout) begin
                        state <= HUNT;
                    end else if (good_next >= LOCK_NEED && vok_next) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        err    <= '0;
                    end
                end
                LOCKED: begin
                    if (timeout) begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end else if (bad_h || bad_v) begin
                        sync_err <= 1'b1;
                        err      <= err_inc;
                        if (err_inc >= ERR_LIMIT) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end
                    end else if (hedge) begin
                        err <= '0;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hvsync_decoder.sv
// Bench for hvsync_decoder driven by a behavioural sync generator on a scaled 40 x 20 raster.
module tb_hvsync_decoder;

    localparam int H_TOTAL   = 40;
    localparam int V_TOTAL   = 20;
    localparam int H_DISPLAY = 24;
    localparam int V_DISPLAY = 12;
    localparam int HS_START  = 30;
    localparam int HS_LEN    = 5;
    localparam int VS_START  = 15;
    localparam int VS_LEN    = 3;
    localparam int FRAME     = H_TOTAL * V_TOTAL;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic       locked;
    logic [9:0] line_len;
    logic       sync_err;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       de;
    } pos_t;

    pos_t exp_q[$];
    int   line_q[$];

    int check_count = 0;
    int fail_count  = 0;
    int gh = 0;
    int gv = 0;
    int cur_len = H_TOTAL;
    int frame_lines = V_TOTAL;
    bit kill_h = 0;
    bit track = 0;
    bit line_chk = 0;
    bit hs_prev = 0;
    bit vs_prev = 0;
    bit h_rise = 0;
    bit v_rise = 0;
    int since_h = 10000;
    int err_pulses = 0;

    hvsync_decoder #(
        .H_DISPLAY  (H_DISPLAY),
        .V_DISPLAY  (V_DISPLAY),
        .H_TOTAL    (H_TOTAL),
        .V_TOTAL    (V_TOTAL),
        .H_EDGE_POS (HS_START + 1),
        .V_EDGE_POS (VS_START),
        .LOCK_LINES (4),
        .UNLOCK_ERRS(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hpos      (hpos),
        .vpos      (vpos),
        .display_on(display_on),
        .locked    (locked),
        .line_len  (line_len),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // One generator clock: drive syncs at the negedge, queue what the decoder must show after the posedge.
    task automatic applyStimulus();
        int   nh;
        int   nv;
        pos_t e;
        hsync_in = !kill_h && gh >= HS_START && gh < HS_START + HS_LEN;
        vsync_in = gv >= VS_START && gv < VS_START + VS_LEN;
        h_rise = hsync_in && !hs_prev;
        v_rise = vsync_in && !vs_prev;
        hs_prev = hsync_in;
        vs_prev = vsync_in;
        since_h++;
        if (h_rise) begin
            if (line_chk) line_q.push_back(since_h);
            since_h = 0;
        end
        nh = gh + 1;
        nv = gv;
        if (nh >= cur_len) begin
            nh = 0;
            nv = gv + 1;
            if (nv >= frame_lines) nv = 0;
        end
        if (track) begin
            e.h  = 9'(nh);
            e.v  = 9'(nv);
            e.de = (nh < H_DISPLAY) && (nv < V_DISPLAY);
            exp_q.push_back(e);
        end
        @(posedge clk);
        gh = nh;
        gv = nv;
        @(negedge clk);
        if (sync_err === 1'b1) err_pulses++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("track_hpos", 32'(hpos), 32'(e.h));
            checkOutput("track_vpos", 32'(vpos), 32'(e.v));
            checkOutput("track_display_on", 32'(display_on), 32'(e.de));
        end
        if (line_q.size() > 0) begin
            checkOutput("line_len", 32'(line_len), line_q.pop_front());
        end
    endtask

    task automatic runUntil(input int line, input int col);
        int n = 0;
        while (!(gv == line && gh == col) && n < 3 * FRAME) begin
            applyStimulus();
            n++;
        end
    endtask

    task automatic waitLock(input string tag);
        int n = 0;
        while (locked !== 1'b1 && n < 4 * FRAME) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(locked), 1);
    endtask

    task automatic runToRise();
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!h_rise && n < 2 * H_TOTAL);
    endtask

    initial begin
        int vcount;
        int rises;
        bit prev_locked;

        repeat (3) @(negedge clk);
        checkOutput("rst_hpos", 32'(hpos), 0);
        checkOutput("rst_vpos", 32'(vpos), 0);
        checkOutput("rst_line_len", 32'(line_len), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_sync_err", 32'(sync_err), 0);
        checkOutput("rst_display_on", 32'(display_on), 0);
        reset = 1'b1;

        $display("[TB] initial lock");
        vcount = 0;
        prev_locked = 0;
        for (int n = 0; n < 3 * FRAME && vcount < 2; n++) begin
            applyStimulus();
            if (v_rise) begin
                vcount++;
                if (vcount == 1) checkOutput("lock_first_vedge", 32'(locked), 0);
                if (vcount == 2) checkOutput("lock_before_second_vedge", 32'(prev_locked), 0);
            end
            prev_locked = locked;
        end
        checkOutput("lock_vedge_count", vcount, 2);
        checkOutput("lock_second_vedge", 32'(locked), 1);

        $display("[TB] tracking one frame");
        err_pulses = 0;
        line_chk = 1;
        track = 1;
        repeat (FRAME) applyStimulus();
        track = 0;
        checkOutput("clean_err_pulses", err_pulses, 0);
        checkOutput("clean_locked", 32'(locked), 1);
        checkOutput("clean_line_len", 32'(line_len), H_TOTAL);

        $display("[TB] one stretched line");
        runUntil(2, 0);
        err_pulses = 0;
        cur_len = H_TOTAL + 1;
        runUntil(3, 0);
        cur_len = H_TOTAL;
        runToRise();
        checkOutput("stretch_sync_err", 32'(sync_err), 1);
        checkOutput("stretch_line_len", 32'(line_len), H_TOTAL + 1);
        runUntil(5, 0);
        checkOutput("stretch_err_pulses", err_pulses, 1);
        checkOutput("stretch_locked", 32'(locked), 1);

        $display("[TB] three short lines");
        runUntil(2, 0);
        err_pulses = 0;
        cur_len = H_TOTAL - 2;
        rises = 0;
        for (int n = 0; n < 6 * H_TOTAL && rises < 4; n++) begin
            applyStimulus();
            if (h_rise) begin
                rises++;
                checkOutput("short_sync_err", 32'(sync_err), 32'(rises >= 2));
                checkOutput("short_locked", 32'(locked), 32'(rises < 4));
            end
            if (gv == 5 && gh == 0) cur_len = H_TOTAL;
        end
        checkOutput("short_err_pulses", err_pulses, 3);
        cur_len = H_TOTAL;
        waitLock("relock_after_short");

        $display("[TB] hsync stuck low");
        runUntil(2, 0);
        runToRise();
        kill_h = 1;
        err_pulses = 0;
        for (int k = 1; k <= 2 * H_TOTAL; k++) begin
            applyStimulus();
            if (k == 2 * H_TOTAL - 1) checkOutput("timeout_locked_before", 32'(locked), 1);
            if (k == 2 * H_TOTAL) checkOutput("timeout_locked_after", 32'(locked), 0);
        end
        checkOutput("timeout_err_pulses", err_pulses, 0);
        kill_h = 0;
        waitLock("relock_after_timeout");

        $display("[TB] short frame");
        runUntil(VS_START + 1, 0);
        err_pulses = 0;
        frame_lines = V_TOTAL - 1;
        for (int n = 0; n < 2 * FRAME; n++) begin
            applyStimulus();
            if (gv == 0 && gh == 0) frame_lines = V_TOTAL;
            if (v_rise) break;
        end
        frame_lines = V_TOTAL;
        checkOutput("short_frame_sync_err", 32'(sync_err), 1);
        checkOutput("short_frame_vpos", 32'(vpos), VS_START);
        runUntil(VS_START + 2, 0);
        checkOutput("short_frame_err_pulses", err_pulses, 1);
        checkOutput("short_frame_locked", 32'(locked), 1);

        $display("[TB] reset mid-line");
        line_chk = 0;
        runUntil(3, 10);
        reset = 1'b0;
        #1;
        checkOutput("midrst_hpos", 32'(hpos), 0);
        checkOutput("midrst_vpos", 32'(vpos), 0);
        checkOutput("midrst_line_len", 32'(line_len), 0);
        checkOutput("midrst_locked", 32'(locked), 0);
        checkOutput("midrst_sync_err", 32'(sync_err), 0);
        checkOutput("midrst_display_on", 32'(display_on), 0);
        repeat (3) applyStimulus();
        reset = 1'b1;
        vcount = 0;
        for (int n = 0; n < 3 * FRAME && vcount < 2; n++) begin
            applyStimulus();
            if (v_rise) begin
                vcount++;
                checkOutput("midrst_relock", 32'(locked), 32'(vcount == 2));
            end
        end
        checkOutput("midrst_vedge_count", vcount, 2);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
